// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, the
// divide-by-zero quotient constant and a conditional two's-complement helper.
// Helpers operate on DIV_MAX_W bits; callers zero-extend and truncate, so
// any WIDTH up to DIV_MAX_W is supported.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_MAX_W = 64;

  // Quotient reported for a zero divisor (all ones at any width after truncation)
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_LO = '1;

  // Two's-complement negate when neg is set; the low bits are correct for any
  // narrower operand that was zero-extended into DIV_MAX_W bits.
  function automatic logic [DIV_MAX_W-1:0] cond_negate(input logic [DIV_MAX_W-1:0] v,
                                                       input logic neg);
    return neg ? (~v + DIV_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter. count == WIDTH when value is zero.
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       value,
  output logic [$clog2(WIDTH):0] count
);

  logic found;

  // Scan from the MSB, counting zeros until the first set bit
  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          count = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// start/busy/done handshake, divide-by-zero flag, per-op signed mode.
// Optional build macro DIV_EARLY_TERM_EN: skip the dividend's leading zeros
// so small dividends finish early (results identical, latency shorter).
import div_pkg::*;

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic             sign_a_in;
  logic             sign_b_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] num_init;
  logic [CNT_W-1:0] n_init;

  // Operand signs and magnitudes at accept time
  assign sign_a_in = signed_op & srcA[WIDTH-1];
  assign sign_b_in = signed_op & srcB[WIDTH-1];
  assign abs_a     = WIDTH'(cond_negate(DIV_MAX_W'(srcA), sign_a_in));
  assign abs_b     = WIDTH'(cond_negate(DIV_MAX_W'(srcB), sign_b_in));

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .value(abs_a),
    .count(lz)
  );

  // Leading zeros would only produce zero quotient bits, so shift them out up front
  assign num_init = abs_a << lz;
  assign n_init   = CNT_W'(WIDTH) - lz;
`else
  assign num_init = abs_a;
  assign n_init   = CNT_W'(WIDTH);
`endif

  // One restoring step. The partial remainder stays below the divisor, so it
  // fits WIDTH bits; only the shifted value needs the extra bit for the compare.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_nx;

  assign rem_sh = {rem, num[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, divisor};
  assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
  assign q_nx   = WIDTH'({q, ge});

  // Control FSM and datapath registers; outputs are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      divisor  <= '0;
      num      <= '0;
      rem      <= '0;
      q        <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            div_zero <= 1'b0;
            sign_a   <= sign_a_in;
            sign_b   <= sign_b_in;
            divisor  <= abs_b;
            num      <= num_init;
            rem      <= '0;
            q        <= '0;
            cnt      <= n_init;
            if (srcB == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              hi       <= srcA;
              lo       <= WIDTH'(DIV_ZERO_LO);
            end else if (n_init == '0) begin
              state <= DONE;
              done  <= 1'b1;
              hi    <= '0;
              lo    <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          num <= num << 1;
          rem <= rem_nx;
          q   <= q_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            lo    <= WIDTH'(cond_negate(DIV_MAX_W'(q_nx), sign_a ^ sign_b));
            hi    <= WIDTH'(cond_negate(DIV_MAX_W'(rem_nx), sign_a));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences and randomized ops against a
// 64-bit arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_op(signed_op),
    .srcA(srcA),
    .srcB(srcB),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit division (truncating, remainder follows dividend)
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mlo, output logic [W-1:0] mhi,
                                output logic mdz, output int lat);
    longint la, lb, qq, rr, mag;
    if (b == '0) begin
      mlo = '1;
      mhi = a;
      mdz = 1'b1;
      lat = 0;
      return;
    end
    la  = s ? longint'($signed(a)) : longint'(a);
    lb  = s ? longint'($signed(b)) : longint'(b);
    qq  = la / lb;
    rr  = la % lb;
    mlo = qq[W-1:0];
    mhi = rr[W-1:0];
    mdz = 1'b0;
`ifdef DIV_EARLY_TERM_EN
    mag = (la < 0) ? -la : la;
    lat = 0;
    while (mag > 0) begin
      lat++;
      mag = mag >> 1;
    end
`else
    mag = 0;
    lat = W;
`endif
  endfunction

  // Count edges after the accept edge until done, and busy cycles on the way
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edz,
                        input int elat, input string name);
    int cyc, bcnt;
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    srcA      = a;
    srcB      = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    srcA      = $urandom;
    srcB      = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    wait_done(cyc, bcnt);
    chk({name, "_done"}, W'(done), W'(1));
    chk({name, "_lo"}, lo, elo);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_dz"}, W'(div_zero), W'(edz));
    chk({name, "_lat"}, W'(cyc), W'(elat));
    chk({name, "_busy"}, W'(bcnt), W'(elat));
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] mlo, mhi, ra, rb;
    logic         mdz, rs;
    int           lat, cyc, bcnt;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,       32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[6]  = '{1'b0, 32'd20,         32'd3,        32'd6,        32'd2,        1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0};
    vecs[8]  = '{1'b0, 32'd0,          32'd9,        32'd0,        32'd0,        1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'd0,        32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0};
    vecs[11] = '{1'b0, 32'd3,          32'd1,        32'd3,        32'd0,        1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    srcA      = '0;
    srcB      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_dz", W'(div_zero), W'(0));
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      model(vecs[i].s, vecs[i].a, vecs[i].b, mlo, mhi, mdz, lat);
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dz, lat,
             $sformatf("vec%0d", i));
    end

    // div_zero clears on the next accepted start
    model(1'b0, 32'd5, 32'd0, mlo, mhi, mdz, lat);
    run_op(1'b0, 32'd5, 32'd0, mlo, mhi, mdz, lat, "dz_set");
    chk("dz_held", W'(div_zero), W'(1));
    model(1'b0, 32'd20, 32'd3, mlo, mhi, mdz, lat);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; srcA = 32'd20; srcB = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dz_clear", W'(div_zero), W'(0));
    wait_done(cyc, bcnt);
    chk("dz_next_lo", lo, 32'd6);
    chk("dz_next_hi", hi, 32'd2);

    // start pulsed while RUN is ignored
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mlo, mhi, mdz, lat);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; srcA = 32'h8000_0000; srcB = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1; signed_op = 1'b0; srcA = 32'd100; srcB = 32'd7;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    chk("ign_lo", lo, 32'h8000_0000);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lat", W'(cyc), W'(lat));
    @(posedge clk);
    #1;
    chk("ign_noq_done", W'(done), W'(0));
    chk("ign_noq_busy", W'(busy), W'(0));

    // back-to-back: new start during the done cycle
    model(1'b0, 32'd1000, 32'd10, mlo, mhi, mdz, lat);
    run_op(1'b0, 32'd1000, 32'd10, mlo, mhi, mdz, lat, "b2b_a");
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; srcA = 32'd77; srcB = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    model(1'b1, 32'hFFFF_FF9C, 32'd7, mlo, mhi, mdz, lat);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; srcA = 32'hFFFF_FF9C; srcB = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("b2b_lo", lo, 32'hFFFF_FFF2);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);
    chk("b2b_lat", W'(cyc), W'(lat));

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom >> $urandom_range(0, 31);
      if (rs && $urandom_range(0, 1) == 1) ra = -ra;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = $urandom;
        default: rb = ($urandom >> $urandom_range(0, 31));
      endcase
      model(rs, ra, rb, mlo, mhi, mdz, lat);
      run_op(rs, ra, rb, mlo, mhi, mdz, lat, $sformatf("rnd%0d", i));
    end

    // reset during iteration 10 discards the op
    model(1'b0, 32'd100, 32'd7, mlo, mhi, mdz, lat);
    run_op(1'b0, 32'd100, 32'd7, mlo, mhi, mdz, lat, "pre_rst");
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; srcA = 32'h1234_5678; srcB = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_done", W'(done), W'(0));
    chk("mid_rst_hi", hi, '0);
    chk("mid_rst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) bcnt++;
    end
    chk("post_rst_idle", W'(bcnt), W'(0));
    model(1'b0, 32'd3, 32'd1, mlo, mhi, mdz, lat);
    run_op(1'b0, 32'd3, 32'd1, mlo, mhi, mdz, lat, "post_rst_op");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
